// File: rtl/pool_stream.sv
// Streaming 2x2 stride-2 max/average pooling over one IMG_W x IMG_H frame.
// Keeps one half-row of partial window results; no frame buffer.
module pool_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int AW   = DATA_W + 2;
  localparam int HALF = IMG_W / 2;
  localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int IW   = (HALF > 2) ? $clog2(HALF) : 1;

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic                 mode_q;
  logic [DATA_W-1:0]    h;
  logic signed [AW-1:0] line_buf [HALF];

  logic                 accept;
  logic                 col_end;
  logic                 row_end;
  logic                 win_done;
  logic [IW-1:0]        lb_idx;
  logic signed [AW-1:0] px_x;
  logic signed [AW-1:0] h_x;
  logic signed [AW-1:0] lb;
  logic signed [AW-1:0] pair;
  logic signed [AW-1:0] res;
  logic signed [AW-1:0] res_sh;
  logic [DATA_W-1:0]    res_out;

  // Handshake: a beat moves on a stream when valid && ready in the same cycle.
  // The input is stalled while a pooled result waits downstream, and during clear.
  assign in_ready = !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign win_done = row[0] && col[0];
  assign lb_idx   = IW'(col >> 1);

  // Partial results are widened by two bits so a four-pixel sum never overflows.
  always_comb begin
    px_x = {{2{in_data[DATA_W-1]}}, in_data};
    h_x  = {{2{h[DATA_W-1]}}, h};
    lb   = line_buf[lb_idx];
    if (mode_q) begin
      pair = h_x + px_x;
      res  = lb + pair;
    end else begin
      pair = (h_x > px_x) ? h_x : px_x;
      res  = (lb > pair) ? lb : pair;
    end
    res_sh  = mode_q ? (res >>> 2) : res;
    res_out = res_sh[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == '0 && row == '0) mode_q <= mode;
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Storage needs no reset: every entry is written before it is read in a frame.
  always_ff @(posedge clk) begin
    if (accept && !col[0]) h <= in_data;
    if (accept && !row[0] && col[0]) line_buf[lb_idx] <= pair;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept && win_done) begin
      out_data  <= res_out;
      out_valid <= 1'b1;
      out_last  <= row_end && col_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_stream.sv
// Bench for pool_stream: a 4x4 instance for directed cases and a 28x28 instance
// for random traffic, both scored against a window-level reference model.
module tb_pool_stream;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear     [2];
  logic          mode      [2];
  logic [DW-1:0] in_data   [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] out_data  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          out_last  [2];

  pool_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_small (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]), .mode(mode[0]),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0])
  );

  pool_stream #(.DATA_W(DW), .IMG_W(28), .IMG_H(28)) u_big (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]), .mode(mode[1]),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1])
  );

  int total = 0;
  int bad   = 0;

  int w_of [2] = '{4, 28};
  int h_of [2] = '{4, 28};

  // Reference model state: the frame seen so far, pixel index, latched mode.
  int          fb [2][784];
  int          pix [2];
  logic        fmode [2];
  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];
  logic [16:0] got_q [$];
  logic        acc [2];
  logic        lat_pend [2];
  logic [16:0] lat_v [2];
  logic        stall_pend [2];
  logic [16:0] stall_v [2];
  int          out_cnt [2];
  int          last_cnt [2];
  int          rdy_mode [2];   // 0: always ready, 1: random, 2: held low

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] pk(logic last, int v);
    return {last, v[15:0]};
  endfunction

  function automatic int q_size(int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic q_push(int k, logic [16:0] e);
    if (k == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic q_pop(int k, output logic [16:0] e);
    if (k == 0) e = exp_q0.pop_front();
    else e = exp_q1.pop_front();
  endtask

  task automatic model_reset(int k);
    pix[k] = 0;
    lat_pend[k] = 1'b0;
    stall_pend[k] = 1'b0;
    if (k == 0) exp_q0.delete();
    else exp_q1.delete();
  endtask

  // Observe one instance at the falling edge; inputs are stable until the next rising edge.
  task automatic mon(int k);
    logic [16:0] obs;
    logic [16:0] e;
    int p, r, c, w, s, rv;
    int a [4];
    obs = {out_last[k], out_data[k]};
    acc[k] = 1'b0;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    if (lat_pend[k]) begin
      check("lat_valid", 32'(out_valid[k]), 1);
      check("lat_out", 32'(obs), 32'(lat_v[k]));
      lat_pend[k] = 1'b0;
    end
    if (stall_pend[k]) begin
      check("stall_valid", 32'(out_valid[k]), 1);
      check("stall_hold", 32'(obs), 32'(stall_v[k]));
      stall_pend[k] = 1'b0;
    end
    if (clear[k]) begin
      check("clr_ready", 32'(in_ready[k]), 0);
      if (out_valid[k] && q_size(k) > 0) q_pop(k, e);
      pix[k] = 0;
      return;
    end
    if (out_valid[k] && !out_ready[k]) begin
      check("bp_ready", 32'(in_ready[k]), 0);
      stall_pend[k] = 1'b1;
      stall_v[k] = obs;
    end
    if (out_valid[k] && out_ready[k]) begin
      check("exp_avail", 32'(q_size(k) != 0), 1);
      if (q_size(k) != 0) begin
        q_pop(k, e);
        check("out", 32'(obs), 32'(e));
      end
      out_cnt[k]++;
      if (out_last[k]) last_cnt[k]++;
      if (k == 0) got_q.push_back(obs);
    end
    if (in_valid[k] && in_ready[k]) begin
      acc[k] = 1'b1;
      w = w_of[k];
      p = pix[k];
      if (p == 0) fmode[k] = mode[k];
      fb[k][p] = $signed(in_data[k]);
      r = p / w;
      c = p % w;
      if (r % 2 == 1 && c % 2 == 1) begin
        a[0] = fb[k][(r - 1) * w + c - 1];
        a[1] = fb[k][(r - 1) * w + c];
        a[2] = fb[k][r * w + c - 1];
        a[3] = fb[k][p];
        if (fmode[k]) begin
          s  = a[0] + a[1] + a[2] + a[3];
          rv = s >>> 2;
        end else begin
          rv = a[0];
          for (int j = 1; j < 4; j++) if (a[j] > rv) rv = a[j];
        end
        e = pk(p == w * h_of[k] - 1, rv);
        q_push(k, e);
        lat_pend[k] = 1'b1;
        lat_v[k] = e;
      end
      pix[k] = (p + 1) % (w * h_of[k]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0);
    mon(1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      case (rdy_mode[k])
        0: out_ready[k] = 1'b1;
        1: out_ready[k] = ($urandom_range(0, 3) != 0);
        default: out_ready[k] = 1'b0;
      endcase
    end
  endtask

  task automatic send(int k, logic [15:0] v, int gap);
    in_valid[k] = 1'b0;
    repeat (gap) tick();
    in_data[k] = v;
    in_valid[k] = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (acc[k]) break;
    end
    check("accept", 32'(acc[k]), 1);
  endtask

  task automatic send_frame(int vals [16], int toggle_at, logic m0, logic m1);
    mode[0] = m0;
    for (int i = 0; i < 16; i++) begin
      if (i == toggle_at) mode[0] = m1;
      send(0, 16'(vals[i]), 0);
    end
    in_valid[0] = 1'b0;
  endtask

  task automatic drain(int k);
    in_valid[k] = 1'b0;
    rdy_mode[k] = 0;
    out_ready[k] = 1'b1;
    repeat (4) tick();
    check("drain_empty", 32'(q_size(k)), 0);
  endtask

  task automatic check_got(string tag, logic [16:0] e [4]);
    check({tag, "_n"}, 32'(got_q.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(e[i]));
    got_q.delete();
  endtask

  int seq [16];
  int seq100 [16];
  int avg_v [16] = '{-1, -2, 32767, 32767, -3, -4, 32767, 32767,
                     -32768, -32768, 0, 0, -32768, -32768, 0, 1};

  initial begin
    for (int i = 0; i < 16; i++) begin
      seq[i] = i;
      seq100[i] = i + 100;
    end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clear[k] = 1'b0;
      mode[k] = 1'b0;
      in_data[k] = '0;
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
      rdy_mode[k] = 0;
      out_cnt[k] = 0;
      last_cnt[k] = 0;
      acc[k] = 1'b0;
      fmode[k] = 1'b0;
      model_reset(k);
    end
    #1;
    check("rst_valid", 32'(out_valid[0]), 0);
    check("rst_last", 32'(out_last[0]), 0);
    check("rst_data", 32'(out_data[0]), 0);
    check("rst_ready", 32'(in_ready[0]), 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Max mode, ramp 0..15.
    send_frame(seq, -1, 1'b0, 1'b0);
    drain(0);
    check_got("max_ramp", '{pk(0, 5), pk(0, 7), pk(0, 13), pk(1, 15)});

    // Average mode with rounding and range extremes.
    send_frame(avg_v, -1, 1'b1, 1'b1);
    drain(0);
    check_got("avg_edge", '{pk(0, -3), pk(0, 32767), pk(0, -32768), pk(1, 0)});

    // Backpressure: hold downstream off for five cycles with a result pending.
    mode[0] = 1'b0;
    for (int i = 0; i < 6; i++) send(0, 16'(i), 0);
    rdy_mode[0] = 2;
    out_ready[0] = 1'b0;
    in_data[0] = 16'd6;
    in_valid[0] = 1'b1;
    repeat (5) tick();
    check("bp_noacc", 32'(acc[0]), 0);
    check("bp_hold_data", 32'(out_data[0]), 5);
    rdy_mode[0] = 0;
    out_ready[0] = 1'b1;
    for (int i = 6; i < 16; i++) send(0, 16'(i), 0);
    drain(0);
    check_got("bp_ramp", '{pk(0, 5), pk(0, 7), pk(0, 13), pk(1, 15)});

    // Mode change mid-frame is ignored; next frame (no gap) averages.
    send_frame(seq, 5, 1'b0, 1'b1);
    send_frame(seq, -1, 1'b1, 1'b1);
    drain(0);
    check({"tog_n"}, 32'(got_q.size()), 8);
    got_q = got_q[4:$];
    check_got("tog_avg", '{pk(0, 2), pk(0, 4), pk(0, 10), pk(1, 12)});

    // Clear after nine pixels, with a valid beat offered during clear.
    mode[0] = 1'b0;
    for (int i = 0; i < 9; i++) send(0, 16'(i), 0);
    clear[0] = 1'b1;
    in_data[0] = 16'd99;
    in_valid[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    in_valid[0] = 1'b0;
    tick();
    check("clr_pre_n", 32'(got_q.size()), 2);
    got_q.delete();
    send_frame(seq100, -1, 1'b0, 1'b0);
    drain(0);
    check_got("clr_fresh", '{pk(0, 105), pk(0, 107), pk(0, 113), pk(1, 115)});

    // Asynchronous reset mid-frame while a result is pending.
    for (int i = 0; i < 8; i++) send(0, 16'(i + 40), 0);
    in_valid[0] = 1'b0;
    check("pre_rst_valid", 32'(out_valid[0]), 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid[0]), 0);
    check("arst_last", 32'(out_last[0]), 0);
    check("arst_data", 32'(out_data[0]), 0);
    check("arst_ready", 32'(in_ready[0]), 1);
    tick();
    rst_n = 1'b1;
    tick();
    got_q.delete();
    send_frame(seq, -1, 1'b0, 1'b0);
    drain(0);
    check_got("post_rst", '{pk(0, 5), pk(0, 7), pk(0, 13), pk(1, 15)});

    // Two 28x28 frames of random data, random gaps and random downstream stalls.
    out_cnt[1] = 0;
    last_cnt[1] = 0;
    rdy_mode[1] = 1;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 784; p++) begin
        mode[1] = 1'($urandom_range(0, 1));
        send(1, 16'($urandom), (p == 0) ? 0 : (($urandom_range(0, 3) == 0) ? 1 : 0));
      end
    end
    drain(1);
    check("big_outputs", 32'(out_cnt[1]), 392);
    check("big_lasts", 32'(last_cnt[1]), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming 2×2, stride-2 pooling unit for one feature map of IMG_W × IMG_H signed pixels, selectable max or average mode. Pixels arrive one per accepted beat in raster order on a valid/ready stream. Pooled pixels leave on a second valid/ready stream. Storage is one half-row of partial results, so the block never needs a full-frame buffer. It sits between a convolution stage and the next layer.

## Interface
- DATA_W, 16, signed pixel width (in and out).
- IMG_W, 28, pixels per input row; must be even, ≥ 2.
- IMG_H, 28, rows per input frame; must be even, ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous frame abort; has priority over all other inputs except rst_n.
- mode  in  1  0 = max, 1 = average; sampled only when the frame's first pixel is accepted.
- in_data  in  DATA_W  signed input pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DATA_W  signed pooled pixel.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_last  out  1  qualifies out_data as the final pooled pixel of the frame.

## Operation
- Accept: a pixel transfers when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational).
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance per accepted pixel.
  - col wraps to 0 and row increments at end of row.
  - row wraps to 0 at end of frame.
- mode_q latches mode on acceptance at row=0, col=0. mode_q holds for the whole frame.
- op(a,b) is defined as follows:
  - max mode: signed maximum, DATA_W bits.
  - avg mode: signed sum, sign-extended to DATA_W+2 bits.
- Even col: the pixel is stored in hold register h.
- Odd col: pair = op(h, pixel).
- Even row, odd col: line_buf[col>>1] <= pair. line_buf has IMG_W/2 entries, each DATA_W+2 bits.
- Odd row, odd col: result = op(line_buf[col>>1], pair).
  - In max mode, out_data = result.
  - In avg mode, out_data = result arithmetically shifted right by 2 (floor toward −∞), truncated to DATA_W. This is always exact in range.
  - out_valid <= 1.
  - out_last <= (row == IMG_H-1 && col == IMG_W-1).
- Output register: out_data, out_valid and out_last hold stable while out_valid && !out_ready. They clear on handshake unless a new result loads in the same cycle.
- Frame size: one frame yields (IMG_W/2)·(IMG_H/2) outputs, with exactly one out_last.
- clear:
  - Counters go to 0, and out_valid and out_last go to 0. A pending output is dropped.
  - in_ready is forced to 0 during the clear cycle.
  - line_buf and h contents are don't-care.
- rst_n low: same effect as clear, applied asynchronously. out_data resets to 0. mode_q resets to 0.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, in_ready=1 after reset release. Counters are 0.
- Latency: out_valid rises on the edge that accepts the 4th pixel of a window (odd row, odd col). This is one cycle of registered latency.
- Throughput: 1 pixel/cycle sustained when out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, in_ready=0 and no state changes.
  - A new result and the consumption of the old one in the same cycle is legal. The new result loads and out_valid stays 1.
- mode toggling mid-frame has no effect until the next frame's first accepted pixel.
- clear and a valid input in the same cycle: the input is not accepted, and the next accepted pixel is row 0, col 0.
- Back-to-back frames need no gap. The next frame's first pixel may be accepted the cycle after the last pixel of the previous frame.

## Test plan
- Max mode, IMG_W=IMG_H=4, input 0..15 raster, out_ready=1. Expected outputs are 5, 7, 13, 15, with out_last only on 15, each appearing one cycle after its window completes.
- Avg mode, 4×4, window {−1,−2,−3,−4}. Expected out = −3 (sum −10 floored /4). Window {32767×4} gives 32767. Window {−32768×4} gives −32768.
- Backpressure: hold out_ready=0 for 5 cycles while an output is pending. Required: out_data/out_last stable, in_ready=0, no pixel lost, and the final sequence identical to the unstalled run.
- Toggle mode from 0 to 1 at pixel 5 of a frame. The whole frame pools with max. The next frame, started with mode=1, pools with average.
- Assert clear after 9 pixels of a 4×4 frame, then stream a full frame. Exactly 4 outputs result, matching a fresh run. Assert rst_n low mid-frame and check the reset values immediately, without waiting for a clock edge.
- Defaults 28×28, random signed data, random in_valid/out_ready. There must be 196 outputs per frame matching a reference model, out_last on output 196 only, and two back-to-back frames with no gap.
